prism_sp_unit_tx_q: RTL

PRISM_SP_UNIT_TX_Q -- requirements
Module: prism_sp_unit_tx_q

---
 rtl/prism_sp_config.sv | 32 +++
 rtl/prism_sp_cmd_queue.sv | 52 +++++
 rtl/prism_sp_unit_tx_q.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prism_sp_config.sv
// Shared definitions for the PRISM SP TX queue unit: command encoding,
// DMA queue entry layout and dispatcher states.
package prism_sp_config;

   localparam int NCMDS            = 6;
   localparam int CMD_META_PUSH    = 0;
   localparam int CMD_META_FULL    = 1;
   localparam int CMD_DATA_COUNT   = 2;
   localparam int CMD_DMA_ENQ      = 3;
   localparam int CMD_DMA_STATUS   = 4;
   localparam int CMD_DMA_DONE_CNT = 5;

   // Length field sized for the widest legal LEN_WIDTH; narrower lengths are zero-extended.
   localparam int MAX_LEN_W = 31;

   typedef struct packed {
      logic [31:0]          addr;
      logic [MAX_LEN_W-1:0] len;
      logic                 cont;
   } dma_entry_t;

   typedef enum logic [1:0] {
      DSP_IDLE,
      DSP_WAIT_BUSY,
      DSP_WAIT_DONE
   } dsp_state_e;

   function automatic logic is_onehot(input logic [NCMDS-1:0] v);
      return (v != '0) && ((v & (v - NCMDS'(1))) == '0);
   endfunction

endpackage

// File: rtl/prism_sp_cmd_queue.sv
// Small power-of-2 FIFO for DMA commands; push while full is dropped,
// full is judged on pre-pop occupancy.
module prism_sp_cmd_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/prism_sp_unit_tx_q.sv
// TX-side command unit: metadata push, FIFO/status queries and a queued
// DMA dispatcher that issues one transfer at a time to the DMA engine.
module prism_sp_unit_tx_q
   import prism_sp_config::*;
#(
   parameter int RESULT_WIDTH = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int COUNT_WIDTH  = 10,
   parameter int QDEPTH       = 4,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [NCMDS-1:0]        cmd,
   input  logic [31:0]             rs1,
   input  logic [31:0]             rs2,
   output logic                    result_valid,
   output logic [RESULT_WIDTH-1:0] result,
   input  logic [COUNT_WIDTH-1:0]  tx_data_wr_data_count,
   output logic                    meta_wr_en,
   output logic [31:0]             meta_wr_data,
   input  logic                    meta_full,
   output logic                    dma_start,
   output logic [31:0]             dma_addr,
   output logic [LEN_WIDTH-1:0]    dma_len,
   output logic                    dma_cont,
   input  logic                    dma_busy
);

   localparam int SH  = $clog2(DATA_WIDTH / 8);
   localparam int QCW = $clog2(QDEPTH) + 1;

   logic                    result_valid_q;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic                    meta_wr_en_q;
   logic [31:0]             meta_wr_data_q;
   logic [15:0]             done_cnt_q;
   dsp_state_e              state_q;
   logic                    dma_start_q, dma_cont_q;
   logic [31:0]             dma_addr_q;
   logic [LEN_WIDTH-1:0]    dma_len_q;

   logic       accept, cmd_ok, clr_done, complete, q_pop;
   dma_entry_t enq_entry, q_head;
   logic       q_full, q_empty;
   logic [QCW-1:0] q_count;

   logic [RESULT_WIDTH+COUNT_WIDTH+SH-1:0] dc_wide;
   logic [RESULT_WIDTH+15:0]               done_wide;
   logic                                   unused_bits;

   assign cmd_ready = ~result_valid_q;
   assign accept    = cmd_valid & cmd_ready;
   assign cmd_ok    = accept & is_onehot(cmd);
   assign clr_done  = cmd_ok & cmd[CMD_DMA_DONE_CNT];
   assign complete  = (state_q == DSP_WAIT_DONE) & ~dma_busy;
   assign q_pop     = (state_q == DSP_IDLE) & ~q_empty & ~dma_busy;

   assign enq_entry.addr = rs1;
   assign enq_entry.len  = MAX_LEN_W'(rs2[LEN_WIDTH-1:0]);
   assign enq_entry.cont = rs2[31];

   prism_sp_cmd_queue #(
      .WIDTH ($bits(dma_entry_t)),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_ok & cmd[CMD_DMA_ENQ]),
      .data_i  (enq_entry),
      .pop_i   (q_pop),
      .head_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Byte count = word count scaled by bytes per FIFO word.
   assign dc_wide     = {{(RESULT_WIDTH+SH){1'b0}}, tx_data_wr_data_count} << SH;
   assign done_wide   = {{RESULT_WIDTH{1'b0}}, done_cnt_q};
   assign unused_bits = ^{rs2, q_head.len};

   always_comb begin
      result_d = '0;
      if (is_onehot(cmd)) begin
         if (cmd[CMD_META_FULL])         result_d[0] = meta_full;
         else if (cmd[CMD_DATA_COUNT])   result_d = dc_wide[RESULT_WIDTH-1:0];
         else if (cmd[CMD_DMA_ENQ])      result_d[0] = q_full;
         else if (cmd[CMD_DMA_STATUS]) begin
            result_d[0]     = (state_q != DSP_IDLE) | dma_busy;
            result_d[QCW:1] = q_count;
         end
         else if (cmd[CMD_DMA_DONE_CNT]) result_d = done_wide[RESULT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_valid_q <= 1'b0;
         result_q       <= '0;
         meta_wr_en_q   <= 1'b0;
         meta_wr_data_q <= '0;
      end else begin
         result_valid_q <= accept;
         if (accept) result_q <= result_d;
         meta_wr_en_q <= cmd_ok & cmd[CMD_META_PUSH];
         if (cmd_ok & cmd[CMD_META_PUSH]) meta_wr_data_q <= rs1;
      end
   end

   // A completion landing on the same cycle as a read-and-clear is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         done_cnt_q <= '0;
      else if (clr_done)
         done_cnt_q <= complete ? 16'd1 : 16'd0;
      else if (complete && done_cnt_q != 16'hFFFF)
         done_cnt_q <= done_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DSP_IDLE;
         dma_start_q <= 1'b0;
         dma_addr_q  <= '0;
         dma_len_q   <= '0;
         dma_cont_q  <= 1'b0;
      end else begin
         dma_start_q <= 1'b0;
         case (state_q)
            DSP_IDLE: if (q_pop) begin
               dma_start_q <= 1'b1;
               dma_addr_q  <= q_head.addr;
               dma_len_q   <= q_head.len[LEN_WIDTH-1:0];
               dma_cont_q  <= q_head.cont;
               state_q     <= DSP_WAIT_BUSY;
            end
            DSP_WAIT_BUSY: if (dma_busy) state_q <= DSP_WAIT_DONE;
            DSP_WAIT_DONE: if (!dma_busy) state_q <= DSP_IDLE;
            default: state_q <= DSP_IDLE;
         endcase
      end
   end

   assign result_valid = result_valid_q;
   assign result       = result_q;
   assign meta_wr_en   = meta_wr_en_q;
   assign meta_wr_data = meta_wr_data_q;
   assign dma_start    = dma_start_q;
   assign dma_addr     = dma_addr_q;
   assign dma_len      = dma_len_q;
   assign dma_cont     = dma_cont_q;

endmodule
